mdu_iter: RTL and testbench



---
 rtl/mdu_iter_pkg.sv | 49 ++++
 rtl/mdu_iter.sv | 244 ++++++++++++++++++++++++
 tb/tb_mdu_iter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter_pkg
// Description : Shared definitions for the iterative multiply/divide unit:
//               funct3 operation codes and small decode helpers that say
//               how each operation treats its operands and which half of
//               the widened result it returns.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_iter_pkg;

    // funct3 encodings of the RV32M/RV64M instructions
    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    // Divide family occupies the upper half of the funct3 space
    function automatic logic op_is_div(input logic [2:0] f);
        return f[2];
    endfunction

    // REM / REMU return the remainder rather than the quotient
    function automatic logic op_is_rem(input logic [2:0] f);
        return f[2] & f[1];
    endfunction

    // rs1 is interpreted as signed by MULH, MULHSU, DIV and REM
    function automatic logic op_a_signed(input logic [2:0] f);
        return (f == MDU_MULH) || (f == MDU_MULHSU) ||
               (f == MDU_DIV)  || (f == MDU_REM);
    endfunction

    // rs2 is interpreted as signed by MULH, DIV and REM only
    function automatic logic op_b_signed(input logic [2:0] f);
        return (f == MDU_MULH) || (f == MDU_DIV) || (f == MDU_REM);
    endfunction

    // MULH / MULHSU / MULHU return the upper half of the product
    function automatic logic op_sel_high(input logic [2:0] f);
        return (f == MDU_MULH) || (f == MDU_MULHSU) || (f == MDU_MULHU);
    endfunction

endpackage : mdu_iter_pkg
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter
// Description : Iterative multiply/divide unit for the EX stage. Radix-2
//               shift-add multiply, restoring divide, one iteration per
//               clock, with a direct path to DONE for divide-by-zero and
//               signed overflow. Signs are stripped on entry and applied
//               once in FIX by a shared negate/select stage.
// Revision    : 1.0 - initial release
//
// Ports
//   clk    : clock
//   reset  : synchronous active-high reset
//   start  : launch an operation (honoured only in IDLE, without flush)
//   flush  : abort the operation in flight, no done is produced
//   op     : funct3 operation code (see mdu_iter_pkg)
//   a, b   : rs1 / rs2 operands
//   busy   : stall request, registered
//   done   : one-cycle completion pulse, registered
//   result : operation result, held until overwritten by a later operation
// ============================================================================
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    import mdu_iter_pkg::*;

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] c_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_op;
    logic [CW-1:0]         r_cnt;
    logic [2*XLEN-1:0]     r_acc;     // {hi, lo}: product, or {rem, quot}
    logic [XLEN-1:0]       r_opb;     // multiplicand / divisor magnitude
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_busy;
    logic                  r_done;
    logic [XLEN-1:0]       r_result;

    // ------------------------------------------------------------------
    // Launch decode
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_val;

    assign w_accept  = (r_state == S_IDLE) && start && !flush;
    assign w_sa      = op_a_signed(op) & a[XLEN-1];
    assign w_sb      = op_b_signed(op) & b[XLEN-1];
    assign w_a_mag   = w_sa ? -a : a;
    assign w_b_mag   = w_sb ? -b : b;

    assign w_div0    = op_is_div(op) && (b == '0);
    // Signed overflow only exists for the signed divide ops (op[0] == 0)
    assign w_ovf     = op_is_div(op) && !op[0] && (a == c_MIN) && (b == '1);
    assign w_special = w_div0 || w_ovf;

    always_comb begin
        w_special_val = '0;
        if (w_div0) begin
            w_special_val = op_is_rem(op) ? a : '1;
        end else if (w_ovf) begin
            w_special_val = op_is_rem(op) ? '0 : a;
        end
    end

    // ------------------------------------------------------------------
    // One iteration of each algorithm
    // ------------------------------------------------------------------
    // Multiply: the multiplier sits in the low half and is consumed from
    // bit 0; the carry of the partial-sum add shifts into the top bit.
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opb};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]}
                                 : {1'b0, r_acc[2*XLEN-1:1]};

    // Divide: the shifted remainder needs one extra bit before the compare,
    // the remainder after restoring always fits back into XLEN bits.
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_rem_diff;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem_new;
    logic [2*XLEN-1:0] w_div_next;

    assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_opb};
    assign w_ge       = (w_rem_sh >= {1'b0, r_opb});
    assign w_rem_new  = w_ge ? w_rem_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_div_next = {w_rem_new, r_acc[XLEN-2:0], w_ge};

    // ------------------------------------------------------------------
    // Shared sign fix-up: one 2*XLEN negator serves the product, the
    // quotient and the remainder; a final select picks the returned half.
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_fix_in;
    logic              w_fix_neg;
    logic [2*XLEN-1:0] w_fix_out;
    logic [XLEN-1:0]   w_fix_res;

    always_comb begin
        w_fix_in = r_acc;
        if (op_is_div(r_op)) begin
            w_fix_in = op_is_rem(r_op) ? {{XLEN{1'b0}}, r_acc[2*XLEN-1:XLEN]}
                                       : {{XLEN{1'b0}}, r_acc[XLEN-1:0]};
        end
    end

    assign w_fix_neg = op_is_rem(r_op) ? r_neg_r : r_neg_q;
    assign w_fix_out = w_fix_neg ? -w_fix_in : w_fix_in;
    assign w_fix_res = op_sel_high(r_op) ? w_fix_out[2*XLEN-1:XLEN]
                                         : w_fix_out[XLEN-1:0];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // Both algorithms start from {0, |a|} with |b| as
                        // the multiplicand / divisor.
                        r_op    <= op;
                        r_cnt   <= CW'(XLEN);
                        r_acc   <= {{XLEN{1'b0}}, w_a_mag};
                        r_opb   <= w_b_mag;
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        if (w_special) begin
                            r_result <= w_special_val;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= op_is_div(r_op) ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    // An aborted operation must leave the old result visible
                    if (!flush) begin
                        r_result <= w_fix_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered handshake. busy trails the state by one cycle so that it
    // still covers the done cycle, which is itself registered from DONE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (r_state != S_IDLE) && !flush;
            r_done <= (r_state == S_DONE) && !flush;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule : mdu_iter
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_iter
// Description : Self-checking bench for mdu_iter (XLEN = 32). A table of
//               directed operations with hand-computed results and
//               latencies, followed by flush, reset and ignored-start
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;

    localparam int XLEN    = 32;
    localparam int LAT_N   = XLEN + 2;   // start edge to done, normal path
    localparam int LAT_S   = 1;          // start edge to done, special path
    localparam int TIMEOUT = 200;

    logic            clk;
    logic            reset;
    logic            start;
    logic            flush;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int n_checks;
    int n_fail;

    mdu_iter #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one operation and follow it to its done pulse.
    task automatic run_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                          output logic [31:0] res, output int lat, output int bcnt,
                          output logic busy_after);
        bit got;
        @(negedge clk);
        op = o; a = aa; b = bb; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        got = 0; lat = -1; bcnt = 0; res = '0;
        for (int i = 1; i <= TIMEOUT && !got; i++) begin
            @(posedge clk);
            #1;
            if (busy) bcnt++;
            if (done) begin
                got = 1;
                lat = i;
                res = result;
            end
        end
        @(posedge clk);
        #1;
        busy_after = busy;
    endtask

    logic [31:0] res;
    int          lat;
    int          bcnt;
    logic        bafter;
    logic [31:0] last_exp;
    int          dcnt;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;

        //            name          op      a             b             expected      latency
        vecs.push_back('{"MUL",      3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, LAT_N});
        vecs.push_back('{"MULH",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, LAT_N});
        vecs.push_back('{"MULHU",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_N});
        vecs.push_back('{"MULHSU",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_N});
        vecs.push_back('{"MULH_n1",  3'b001, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, LAT_N});
        vecs.push_back('{"MUL_sh",   3'b000, 32'h12345678, 32'h00000010, 32'h23456780, LAT_N});
        vecs.push_back('{"MULHU_sh", 3'b011, 32'h12345678, 32'h00000010, 32'h00000001, LAT_N});
        vecs.push_back('{"DIV",      3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, LAT_N});
        vecs.push_back('{"REM",      3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, LAT_N});
        vecs.push_back('{"DIV_nb",   3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, LAT_N});
        vecs.push_back('{"REM_nb",   3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, LAT_N});
        vecs.push_back('{"DIVU",     3'b101, 32'd100,      32'd7,        32'd14,       LAT_N});
        vecs.push_back('{"REMU",     3'b111, 32'd100,      32'd7,        32'd2,        LAT_N});
        vecs.push_back('{"DIVU_big", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_N});
        vecs.push_back('{"REMU_big", 3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_N});
        vecs.push_back('{"DIVU_z",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, LAT_S});
        vecs.push_back('{"DIV_z",    3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, LAT_S});
        vecs.push_back('{"REM_z",    3'b110, 32'd5,        32'd0,        32'd5,        LAT_S});
        vecs.push_back('{"REMU_z",   3'b111, 32'd5,        32'd0,        32'd5,        LAT_S});
        vecs.push_back('{"DIV_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_S});
        vecs.push_back('{"REM_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_S});

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_busy",   {63'd0, busy}, 64'd0);
        chk("reset_done",   {63'd0, done}, 64'd0);
        chk("reset_result", {32'd0, result}, 64'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bcnt, bafter);
            chk({vecs[i].name, "_result"}, {32'd0, res}, {32'd0, vecs[i].exp});
            chk({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
            chk({vecs[i].name, "_busycycles"}, 64'(bcnt), 64'(vecs[i].lat));
            chk({vecs[i].name, "_busy_after"}, {63'd0, bafter}, 64'd0);
        end
        last_exp = vecs[vecs.size()-1].exp;

        // Flush 10 cycles into a DIV: no done, busy drops, result unchanged
        @(negedge clk);
        op = 3'b100; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy",   {63'd0, busy}, 64'd0);
        chk("flush_done",   {63'd0, done}, 64'd0);
        chk("flush_result", {32'd0, result}, {32'd0, last_exp});
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dcnt++;
        end
        chk("flush_quiet", 64'(dcnt), 64'd0);
        run_op(3'b000, 32'd3, 32'd4, res, lat, bcnt, bafter);
        chk("post_flush_mul", {32'd0, res}, 64'd12);
        chk("post_flush_lat", 64'(lat), 64'(LAT_N));

        // Reset pulsed mid-MUL
        @(negedge clk);
        op = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_busy",   {63'd0, busy}, 64'd0);
        chk("midrst_done",   {63'd0, done}, 64'd0);
        chk("midrst_result", {32'd0, result}, 64'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        chk("midrst_nodone", 64'(dcnt), 64'd0);

        // Start pulses while busy must be ignored
        @(negedge clk);
        op = 3'b000; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dcnt = 0;
        res  = '0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (i == 5 || i == 20) begin
                op = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                dcnt++;
                res = result;
            end
        end
        start = 1'b0;
        chk("ignstart_done_count", 64'(dcnt), 64'd1);
        chk("ignstart_result", {32'd0, res}, 64'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mdu_iter
`default_nettype wire
